main_memory_ctrl: RTL and testbench

//  Parametrised synchronous main memory for the MIC-1 datapath.
//  - Word port (MAR/MDR): 32-bit word read/write.
//  - Byte port (PC/MBR): instruction-byte fetch.
//  - Read latency is configurable; a per-request valid handshake is provided.
//  - Out-of-range and read/write-collision conditions are detected.
//  - Sits between the datapath register file and the control store sequencer.

---
 rtl/main_memory_ctrl.sv | 132 +++++++++++++
 tb/tb_main_memory_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/main_memory_ctrl.sv
// Synchronous main memory for the MIC-1 datapath: word port (MAR/MDR) plus byte fetch port (PC/MBR).
// Optional parity storage/checking is enabled by defining MAIN_MEM_PARITY_EN.
module main_memory_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 2**ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDR_W-1:0]                   mar,
    input  logic                                rd,
    input  logic                                wr,
    input  logic [DATA_W-1:0]                   wdata,
    output logic [DATA_W-1:0]                   rdata,
    output logic                                rd_valid,
    input  logic [ADDR_W+$clog2(DATA_W/8)-1:0]  pc,
    input  logic                                fetch,
    output logic [7:0]                          mbr,
    output logic                                fetch_valid,
    output logic                                addr_err,
    output logic                                collision
`ifdef MAIN_MEM_PARITY_EN
    ,
    output logic                                parity_err
`endif
);
    localparam int BSEL_W = $clog2(DATA_W/8);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] fidx;
    logic [BSEL_W-1:0] bsel;
    logic              w_ok, f_ok, w_hit;
    logic [DATA_W-1:0] rd_word, f_word;
    logic [7:0]        f_byte;
    logic              rv_in, fv_in, err_in, col_in;

    assign fidx  = pc[ADDR_W+BSEL_W-1:BSEL_W];
    assign bsel  = pc[BSEL_W-1:0];
    assign w_ok  = {1'b0, mar}  < DEPTH_V;
    assign f_ok  = {1'b0, fidx} < DEPTH_V;
    assign w_hit = wr && w_ok && (fidx == mar);

    // A word read that shares its cycle with a write is a collision and is dropped,
    // so only the byte port needs the write-first bypass.
    assign rd_word = w_ok ? mem[mar[IDX_W-1:0]] : '0;
    assign f_word  = !f_ok ? '0 : (w_hit ? wdata : mem[fidx[IDX_W-1:0]]);
    assign f_byte  = f_word[{bsel, 3'b000} +: 8];

    assign rv_in  = rd && !wr;
    assign fv_in  = fetch;
    assign err_in = ((rd || wr) && !w_ok) || (fetch && !f_ok);
    assign col_in = rd && wr;

    always_ff @(posedge clk) begin
        if (wr && w_ok)
            mem[mar[IDX_W-1:0]] <= wdata;
    end

    logic [RD_LAT-1:0] rv_q, fv_q, err_q, col_q;
    logic [DATA_W-1:0] rd_q [RD_LAT];
    logic [7:0]        fb_q [RD_LAT];

    // Each data stage only loads when its incoming valid is set, so the last
    // stage naturally holds the previous result between valid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rv_q  <= '0;
            fv_q  <= '0;
            err_q <= '0;
            col_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                rd_q[i] <= '0;
                fb_q[i] <= '0;
            end
        end else begin
            rv_q[0]  <= rv_in;
            fv_q[0]  <= fv_in;
            err_q[0] <= err_in;
            col_q[0] <= col_in;
            if (rv_in) rd_q[0] <= rd_word;
            if (fv_in) fb_q[0] <= f_byte;
            for (int i = 1; i < RD_LAT; i++) begin
                rv_q[i]  <= rv_q[i-1];
                fv_q[i]  <= fv_q[i-1];
                err_q[i] <= err_q[i-1];
                col_q[i] <= col_q[i-1];
                if (rv_q[i-1]) rd_q[i] <= rd_q[i-1];
                if (fv_q[i-1]) fb_q[i] <= fb_q[i-1];
            end
        end
    end

    assign rdata       = rd_q[RD_LAT-1];
    assign mbr         = fb_q[RD_LAT-1];
    assign rd_valid    = rv_q[RD_LAT-1];
    assign fetch_valid = fv_q[RD_LAT-1];
    assign addr_err    = err_q[RD_LAT-1];
    assign collision   = col_q[RD_LAT-1];

`ifdef MAIN_MEM_PARITY_EN
    logic              mem_par [DEPTH];
    logic              rd_perr, f_perr, pe_in;
    logic [RD_LAT-1:0] pe_q;

    always_ff @(posedge clk) begin
        if (wr && w_ok)
            mem_par[mar[IDX_W-1:0]] <= ^wdata;
    end

    // Bypassed write data is freshly computed, so it cannot carry a parity fault.
    assign rd_perr = w_ok && ((^mem[mar[IDX_W-1:0]]) != mem_par[mar[IDX_W-1:0]]);
    assign f_perr  = f_ok && !w_hit && ((^mem[fidx[IDX_W-1:0]]) != mem_par[fidx[IDX_W-1:0]]);
    assign pe_in   = (rv_in && rd_perr) || (fv_in && f_perr);

    always_ff @(posedge clk) begin
        if (rst) begin
            pe_q <= '0;
        end else begin
            pe_q[0] <= pe_in;
            for (int i = 1; i < RD_LAT; i++)
                pe_q[i] <= pe_q[i-1];
        end
    end

    assign parity_err = pe_q[RD_LAT-1];
`endif

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed table-driven bench for main_memory_ctrl, built with DEPTH=256 and RD_LAT=2.
module tb_main_memory_ctrl;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 2;
    localparam int PC_W   = ADDR_W + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] mar = '0;
    logic              rd = 1'b0, wr = 1'b0, fetch = 1'b0;
    logic [DATA_W-1:0] wdata = '0;
    logic [PC_W-1:0]   pc = '0;
    logic [DATA_W-1:0] rdata;
    logic              rd_valid, fetch_valid, addr_err, collision;
    logic [7:0]        mbr;
`ifdef MAIN_MEM_PARITY_EN
    logic              parity_err;
`endif

    main_memory_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .mar(mar), .rd(rd), .wr(wr), .wdata(wdata),
        .rdata(rdata), .rd_valid(rd_valid), .pc(pc), .fetch(fetch), .mbr(mbr),
        .fetch_valid(fetch_valid), .addr_err(addr_err), .collision(collision)
`ifdef MAIN_MEM_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Row k's expectations are what is visible after the edge that samples row k,
    // i.e. the outcome of row k-1's request (RD_LAT=2).
    typedef struct {
        logic              rst, rd, wr, fetch;
        logic [ADDR_W-1:0] mar;
        logic [DATA_W-1:0] wdata;
        logic [PC_W-1:0]   pc;
        logic              e_rv;
        logic [DATA_W-1:0] e_rdata;
        logic              e_fv;
        logic [7:0]        e_mbr;
        logic              e_err, e_col;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic r, logic rdq, logic wrq, logic [ADDR_W-1:0] a,
                                logic [DATA_W-1:0] wd, logic f, logic [PC_W-1:0] p,
                                logic erv, logic [DATA_W-1:0] erd, logic efv,
                                logic [7:0] emb, logic eerr, logic ecol);
        vec_t v;
        v.rst = r;  v.rd = rdq;  v.wr = wrq;  v.mar = a;  v.wdata = wd;
        v.fetch = f;  v.pc = p;
        v.e_rv = erv;  v.e_rdata = erd;  v.e_fv = efv;  v.e_mbr = emb;
        v.e_err = eerr;  v.e_col = ecol;
        return v;
    endfunction

    task automatic check(input string name, input logic erv, input logic [DATA_W-1:0] erd,
                         input logic efv, input logic [7:0] emb, input logic eerr,
                         input logic ecol);
        logic [43:0] act, exp;
        act = {rd_valid, rdata, fetch_valid, mbr, addr_err, collision};
        exp = {erv, erd, efv, emb, eerr, ecol};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got rv=%b rdata=%h fv=%b mbr=%h err=%b col=%b, want rv=%b rdata=%h fv=%b mbr=%h err=%b col=%b",
                     name, rd_valid, rdata, fetch_valid, mbr, addr_err, collision,
                     erv, erd, efv, emb, eerr, ecol);
        end
    endtask

    task automatic drive(input logic r, input logic rdq, input logic wrq,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                         input logic f, input logic [PC_W-1:0] p);
        rst = r;  rd = rdq;  wr = wrq;  mar = a;  wdata = wd;  fetch = f;  pc = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rst rd wr mar  wdata          f  pc    rv rdata  fv mbr   err col
        tbl[0]  = mk(1, 1, 0, 9'd0,   32'h0,        1, 11'd0,    0, 32'h0,  0, 8'h00, 0, 0);
        tbl[1]  = mk(1, 1, 0, 9'd10,  32'h0,        1, 11'd4,    0, 32'h0,  0, 8'h00, 0, 0);
        tbl[2]  = mk(0, 0, 1, 9'd10,  32'h63,       0, 11'd0,    0, 32'h0,  0, 8'h00, 0, 0);
        tbl[3]  = mk(0, 1, 0, 9'd10,  32'h0,        0, 11'd0,    0, 32'h0,  0, 8'h00, 0, 0);
        tbl[4]  = mk(0, 0, 0, 9'd0,   32'h0,        0, 11'd0,    1, 32'h63, 0, 8'h00, 0, 0);
        tbl[5]  = mk(0, 0, 1, 9'd3,   32'hDDCCBBAA, 0, 11'd0,    0, 32'h63, 0, 8'h00, 0, 0);
        tbl[6]  = mk(0, 0, 0, 9'd0,   32'h0,        1, 11'd12,   0, 32'h63, 0, 8'h00, 0, 0);
        tbl[7]  = mk(0, 0, 0, 9'd0,   32'h0,        1, 11'd13,   0, 32'h63, 1, 8'hAA, 0, 0);
        tbl[8]  = mk(0, 0, 0, 9'd0,   32'h0,        1, 11'd14,   0, 32'h63, 1, 8'hBB, 0, 0);
        tbl[9]  = mk(0, 0, 0, 9'd0,   32'h0,        1, 11'd15,   0, 32'h63, 1, 8'hCC, 0, 0);
        tbl[10] = mk(0, 0, 1, 9'd5,   32'h12345678, 1, 11'd20,   0, 32'h63, 1, 8'hDD, 0, 0);
        tbl[11] = mk(0, 1, 1, 9'd7,   32'h1,        0, 11'd0,    0, 32'h63, 1, 8'h78, 0, 0);
        tbl[12] = mk(0, 1, 0, 9'd7,   32'h0,        0, 11'd0,    0, 32'h63, 0, 8'h78, 0, 1);
        tbl[13] = mk(0, 1, 0, 9'd300, 32'h0,        0, 11'd0,    1, 32'h1,  0, 8'h78, 0, 0);
        tbl[14] = mk(0, 0, 0, 9'd0,   32'h0,        0, 11'd0,    1, 32'h0,  0, 8'h78, 1, 0);
        tbl[15] = mk(0, 0, 1, 9'd266, 32'hBAD,      0, 11'd0,    0, 32'h0,  0, 8'h78, 0, 0);
        tbl[16] = mk(0, 1, 0, 9'd10,  32'h0,        0, 11'd0,    0, 32'h0,  0, 8'h78, 1, 0);
        tbl[17] = mk(0, 0, 1, 9'd255, 32'h11223344, 0, 11'd0,    1, 32'h63, 0, 8'h78, 0, 0);
        tbl[18] = mk(0, 0, 0, 9'd0,   32'h0,        1, 11'd1023, 0, 32'h63, 0, 8'h78, 0, 0);
        tbl[19] = mk(0, 0, 0, 9'd0,   32'h0,        1, 11'd1024, 0, 32'h63, 1, 8'h11, 0, 0);
        tbl[20] = mk(0, 0, 0, 9'd0,   32'h0,        0, 11'd0,    0, 32'h63, 1, 8'h00, 1, 0);
        tbl[21] = mk(0, 0, 0, 9'd0,   32'h0,        0, 11'd0,    0, 32'h63, 0, 8'h00, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].mar, tbl[i].wdata,
                  tbl[i].fetch, tbl[i].pc);
            check($sformatf("vec%0d", i), tbl[i].e_rv, tbl[i].e_rdata, tbl[i].e_fv,
                  tbl[i].e_mbr, tbl[i].e_err, tbl[i].e_col);
        end

        // Out-of-range read killed by a reset one cycle later: no pulse, outputs cleared.
        drive(0, 1, 0, 9'd300, 32'h0, 1, 11'd12);
        check("oob_rd_issue", 0, 32'h63, 0, 8'h00, 0, 0);
        drive(1, 0, 0, 9'd0, 32'h0, 0, 11'd0);
        check("oob_rd_reset", 0, 32'h0, 0, 8'h00, 0, 0);
        drive(0, 0, 0, 9'd0, 32'h0, 0, 11'd0);
        check("oob_rd_after", 0, 32'h0, 0, 8'h00, 0, 0);

        // Memory contents survive reset; back-to-back word reads pulse on consecutive cycles.
        drive(0, 1, 0, 9'd3, 32'h0, 0, 11'd0);
        check("b2b_rd0_issue", 0, 32'h0, 0, 8'h00, 0, 0);
        drive(0, 1, 0, 9'd5, 32'h0, 0, 11'd0);
        check("b2b_rd0", 1, 32'hDDCCBBAA, 0, 8'h00, 0, 0);
        drive(0, 0, 0, 9'd0, 32'h0, 0, 11'd0);
        check("b2b_rd1", 1, 32'h12345678, 0, 8'h00, 0, 0);
        drive(0, 0, 0, 9'd0, 32'h0, 0, 11'd0);
        check("b2b_hold", 0, 32'h12345678, 0, 8'h00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
